// File: rtl/ps2_keyevent_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Brief    : Shared constants, event record and frame-FSM encoding for the
//             PS/2 key-event receiver.
//  Revision : 1.0  initial release
// ============================================================================
package ps2_pkg;

    // Prefix bytes that modify the following key code
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // One decoded key event as stored in the event FIFO
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    // Frame FSM encoding
    localparam int c_STATE_W = 2;
    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // Odd parity: data bits plus parity bit must contain an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_filter.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_sync_filter
//  Brief    : Synchroniser plus persistence filter for one asynchronous PS/2
//             line. The filtered level changes only after FILTER_LEN
//             consecutive synchronised samples disagree with it; o_fall
//             pulses for one cycle when the filtered level drops 1->0.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_din,
    output logic o_level,
    output logic o_fall
);

    localparam int c_CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_level;
    logic                   r_fall;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];

    // Synchroniser chain; idle PS/2 lines are high, so reset to 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
        end
    end

    // Persistence filter: count disagreeing samples, adopt new level on the last one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
        end else if (w_synced != r_level) begin
            if (r_cnt == c_CNT_W'(FILTER_LEN - 1)) begin
                r_cnt   <= '0;
                r_level <= w_synced;
                // level was 1 and is becoming 0 -> falling edge
                r_fall  <= r_level;
            end else begin
                r_cnt  <= r_cnt + c_CNT_W'(1);
                r_fall <= 1'b0;
            end
        end else begin
            r_cnt  <= '0;
            r_fall <= 1'b0;
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_keyevent_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_keyevent_rx
//  Brief    : PS/2 keyboard receiver. Frames bytes on filtered kclk falls,
//             checks parity/stop, aborts stalled frames, folds E0/F0
//             prefixes into key events and queues them in a FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_keyevent_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 32,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_kclk,
    input  logic                        i_kdata,
    output logic                        o_ev_valid,
    input  logic                        i_ev_ready,
    output logic [9:0]                  o_ev_data,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
    output logic                        o_byte_valid,
    output logic [7:0]                  o_rx_byte,
    output logic [31:0]                 o_keycodeout,
    output logic                        o_err_parity,
    output logic                        o_err_frame,
    output logic                        o_err_timeout,
    output logic                        o_overflow
);

    import ps2_pkg::*;

    localparam int c_AW    = $clog2(FIFO_DEPTH);
    localparam int c_CW    = c_AW + 1;
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic w_kclk_lvl;
    logic w_strobe;
    logic w_kdat;
    logic w_kdat_fall_unused;

    ps2_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_kclk_filt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_din   (i_kclk),
        .o_level (w_kclk_lvl),
        .o_fall  (w_strobe)
    );

    ps2_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_kdata_filt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_din   (i_kdata),
        .o_level (w_kdat),
        .o_fall  (w_kdat_fall_unused)
    );

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    ps2_state_e         r_state;
    ps2_state_e         w_state_nxt;
    logic [2:0]         r_bitcnt;
    logic [7:0]         r_shift;
    logic               r_parity;
    logic [c_TMO_W-1:0] r_tmo;
    logic               w_tmo_hit;
    logic               w_start;
    logic               w_shift_en;
    logic               w_par_en;
    logic               w_good;
    logic               w_perr;
    logic               w_ferr;

    // A strobe in the same cycle as expiry counts as activity, so it wins
    assign w_tmo_hit = (r_state != ST_IDLE) && !w_strobe &&
                       (r_tmo == c_TMO_W'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (w_tmo_hit) begin
            w_state_nxt = ST_IDLE;
        end else if (w_strobe) begin
            case (r_state)
                ST_IDLE:   if (!w_kdat) w_state_nxt = ST_DATA;
                ST_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = ST_PARITY;
                ST_PARITY: w_state_nxt = ST_STOP;
                ST_STOP:   w_state_nxt = ST_IDLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output decode: per-strobe actions and end-of-frame verdicts
    always_comb begin
        w_start    = w_strobe && (r_state == ST_IDLE) && !w_kdat;
        w_shift_en = w_strobe && (r_state == ST_DATA);
        w_par_en   = w_strobe && (r_state == ST_PARITY);
        w_good     = 1'b0;
        w_perr     = 1'b0;
        w_ferr     = 1'b0;
        if (w_strobe && (r_state == ST_STOP)) begin
            w_perr = !odd_parity_ok(r_shift, r_parity);
            w_ferr = !w_kdat;
            w_good = !w_perr && !w_ferr;
        end
    end

    // Shift register, bit counter, parity latch and stall timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tmo    <= '0;
        end else begin
            if (w_start) begin
                r_bitcnt <= '0;
            end else if (w_shift_en) begin
                r_shift  <= {w_kdat, r_shift[7:1]};
                r_bitcnt <= r_bitcnt + 3'd1;
            end
            if (w_par_en) begin
                r_parity <= w_kdat;
            end
            if (w_strobe || (r_state == ST_IDLE) || w_tmo_hit) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + c_TMO_W'(1);
            end
        end
    end

    // Status pulses and raw-byte history, one cycle after the stop strobe
    logic        r_byte_valid;
    logic [7:0]  r_rx_byte;
    logic [31:0] r_keycode;
    logic        r_err_parity;
    logic        r_err_frame;
    logic        r_err_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_valid  <= 1'b0;
            r_rx_byte     <= '0;
            r_keycode     <= '0;
            r_err_parity  <= 1'b0;
            r_err_frame   <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_byte_valid  <= w_good;
            r_err_parity  <= w_perr;
            r_err_frame   <= w_ferr;
            r_err_timeout <= w_tmo_hit;
            if (w_good) begin
                r_rx_byte <= r_shift;
                r_keycode <= {r_keycode[23:0], r_shift};
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefix decoder
    // ------------------------------------------------------------------
    logic       r_ext;
    logic       r_brk;
    logic       w_is_prefix;
    logic       w_push;
    ps2_event_t w_push_ev;

    assign w_is_prefix = (r_rx_byte == PS2_EXT) || (r_rx_byte == PS2_BRK);
    assign w_push      = r_byte_valid && !w_is_prefix;
    assign w_push_ev   = '{ext: r_ext, brk: r_brk, code: r_rx_byte};

    // Prefix flags: set by E0/F0, consumed by the next code, dropped on any error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else if (r_err_parity || r_err_frame || r_err_timeout) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else if (r_byte_valid) begin
            if (r_rx_byte == PS2_EXT) begin
                r_ext <= 1'b1;
            end else if (r_rx_byte == PS2_BRK) begin
                r_brk <= 1'b1;
            end else begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [9:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_overflow;
    logic            w_full;
    logic            w_pop;
    logic            w_wr_en;

    assign w_full  = (r_count == c_CW'(FIFO_DEPTH));
    assign w_pop   = (r_count != '0) && i_ev_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands
    assign w_wr_en = w_push && (!w_full || w_pop);

    // Storage, pointers, occupancy and overflow pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_push && w_full && !w_pop;
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= w_push_ev;
                r_wr_ptr        <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_ev_valid    = (r_count != '0);
    assign o_ev_data     = r_mem[r_rd_ptr];
    assign o_fifo_level  = r_count;
    assign o_byte_valid  = r_byte_valid;
    assign o_rx_byte     = r_rx_byte;
    assign o_keycodeout  = r_keycode;
    assign o_err_parity  = r_err_parity;
    assign o_err_frame   = r_err_frame;
    assign o_err_timeout = r_err_timeout;
    assign o_overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyevent_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_keyevent_rx
//  Brief    : Directed self-checking bench for ps2_keyevent_rx.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2_keyevent_rx;

    localparam int c_SYNC  = 2;
    localparam int c_FILT  = 8;
    localparam int c_TMO   = 400;
    localparam int c_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_kclk;
    logic       i_kdata;
    logic       o_ev_valid;
    logic       i_ev_ready;
    logic [9:0] o_ev_data;
    logic [2:0] o_fifo_level;
    logic       o_byte_valid;
    logic [7:0] o_rx_byte;
    logic [31:0] o_keycodeout;
    logic       o_err_parity;
    logic       o_err_frame;
    logic       o_err_timeout;
    logic       o_overflow;

    int checks = 0;
    int errors = 0;

    // Pulse monitors
    int n_bv, n_pe, n_fe, n_to, n_ov;
    int cyc = 0;
    int bv_cyc = -1;
    int evv_cyc = -1;
    logic prev_evv = 1'b0;
    logic [9:0] ev_q[$];

    always #5 clk = ~clk;

    ps2_keyevent_rx #(
        .SYNC_STAGES    (c_SYNC),
        .FILTER_LEN     (c_FILT),
        .TIMEOUT_CYCLES (c_TMO),
        .FIFO_DEPTH     (c_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_kclk        (i_kclk),
        .i_kdata       (i_kdata),
        .o_ev_valid    (o_ev_valid),
        .i_ev_ready    (i_ev_ready),
        .o_ev_data     (o_ev_data),
        .o_fifo_level  (o_fifo_level),
        .o_byte_valid  (o_byte_valid),
        .o_rx_byte     (o_rx_byte),
        .o_keycodeout  (o_keycodeout),
        .o_err_parity  (o_err_parity),
        .o_err_frame   (o_err_frame),
        .o_err_timeout (o_err_timeout),
        .o_overflow    (o_overflow)
    );

    always @(posedge clk) cyc++;

    // Sample outputs on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (o_byte_valid)  begin n_bv++; bv_cyc = cyc; end
        if (o_err_parity)  n_pe++;
        if (o_err_frame)   n_fe++;
        if (o_err_timeout) n_to++;
        if (o_overflow)    n_ov++;
        if (o_ev_valid && !prev_evv) evv_cyc = cyc;
        prev_evv = o_ev_valid;
        if (o_ev_valid && i_ev_ready) ev_q.push_back(o_ev_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        n_bv = 0; n_pe = 0; n_fe = 0; n_to = 0; n_ov = 0;
        ev_q.delete();
    endtask

    task automatic send_bit(input logic b);
        i_kdata = b;
        step(10);
        i_kclk = 1'b0;
        step(20);
        i_kclk = 1'b1;
        step(10);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ bad_par);
        send_bit(~bad_stop);
        i_kdata = 1'b1;
        step(40);
    endtask

    initial begin
        logic [7:0] mk [5];
        mk[0] = 8'h16; mk[1] = 8'h1E; mk[2] = 8'h26; mk[3] = 8'h25; mk[4] = 8'h2E;
        n_bv = 0; n_pe = 0; n_fe = 0; n_to = 0; n_ov = 0;

        // Reset state
        rst_n = 1'b0; i_kclk = 1'b1; i_kdata = 1'b1; i_ev_ready = 1'b1;
        step(5);
        chk("rst_ev_valid", 32'(o_ev_valid), 32'd0);
        chk("rst_level",    32'(o_fifo_level), 32'd0);
        chk("rst_keycode",  o_keycodeout, 32'd0);
        chk("rst_rx_byte",  32'(o_rx_byte), 32'd0);
        rst_n = 1'b1;
        step(5);

        // 1: single make code, latency byte_valid -> ev_valid is one cycle
        clr();
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("t1_bv_count", 32'(n_bv), 32'd1);
        chk("t1_rx_byte",  32'(o_rx_byte), 32'h1C);
        chk("t1_keycode",  o_keycodeout, 32'h0000001C);
        chk("t1_ev_count", 32'(ev_q.size()), 32'd1);
        if (ev_q.size() > 0) chk("t1_ev_data", 32'(ev_q[0]), 32'h01C);
        chk("t1_latency",  32'(evv_cyc - bv_cyc), 32'd1);

        // 2: break code, then extended break
        clr();
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        chk("t2_bv_count", 32'(n_bv), 32'd5);
        chk("t2_ev_count", 32'(ev_q.size()), 32'd2);
        if (ev_q.size() > 1) begin
            chk("t2_ev0", 32'(ev_q[0]), 32'h11C);
            chk("t2_ev1", 32'(ev_q[1]), 32'h375);
        end
        chk("t2_keycode", o_keycodeout, 32'h1CE0F075);

        // 3: parity error, frame error, and error clearing a pending prefix
        clr();
        send_frame(8'h1C, 1'b1, 1'b0);
        chk("t3_perr",      32'(n_pe), 32'd1);
        chk("t3_perr_noev", 32'(ev_q.size()), 32'd0);
        chk("t3_rx_hold",   32'(o_rx_byte), 32'h75);
        send_frame(8'hF0, 1'b0, 1'b1);
        chk("t3_ferr", 32'(n_fe), 32'd1);
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("t3_ev_count", 32'(ev_q.size()), 32'd2);
        if (ev_q.size() > 1) begin
            chk("t3_ev0", 32'(ev_q[0]), 32'h01C);
            chk("t3_ev1", 32'(ev_q[1]), 32'h01C);
        end
        chk("t3_keycode", o_keycodeout, 32'h751C_F01C);

        // 4: stalled frame times out, next frame decodes cleanly
        clr();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        i_kdata = 1'b1;
        step(c_TMO + 50);
        chk("t4_timeout", 32'(n_to), 32'd1);
        chk("t4_no_bv",   32'(n_bv), 32'd0);
        send_frame(8'h15, 1'b0, 1'b0);
        chk("t4_ev_count", 32'(ev_q.size()), 32'd1);
        if (ev_q.size() > 0) chk("t4_ev0", 32'(ev_q[0]), 32'h015);
        chk("t4_no_perr", 32'(n_pe + n_fe), 32'd0);

        // 5: fill FIFO past depth, one overflow, drain in order
        clr();
        i_ev_ready = 1'b0;
        for (int i = 0; i < c_DEPTH + 1; i++) send_frame(mk[i], 1'b0, 1'b0);
        chk("t5_level",    32'(o_fifo_level), 32'd4);
        chk("t5_overflow", 32'(n_ov), 32'd1);
        chk("t5_valid",    32'(o_ev_valid), 32'd1);
        chk("t5_head",     32'(o_ev_data), 32'h016);
        i_ev_ready = 1'b1;
        step(10);
        chk("t5_drain_cnt", 32'(ev_q.size()), 32'd4);
        for (int i = 0; i < c_DEPTH; i++) begin
            if (ev_q.size() > i) chk("t5_drain", 32'(ev_q[i]), 32'(mk[i]));
        end
        chk("t5_level_end", 32'(o_fifo_level), 32'd0);

        // 6a: short kclk glitch with kdata low must not start a frame
        clr();
        i_kdata = 1'b0;
        step(5);
        i_kclk = 1'b0;
        step(3);
        i_kclk = 1'b1;
        step(30);
        i_kdata = 1'b1;
        step(20);
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("t6_glitch_cnt", 32'(ev_q.size()), 32'd1);
        if (ev_q.size() > 0) chk("t6_glitch_ev", 32'(ev_q[0]), 32'h01C);

        // 6b: reset mid-frame with an event queued
        clr();
        i_ev_ready = 1'b0;
        send_frame(8'h2C, 1'b0, 1'b0);
        chk("t6_pre_level", 32'(o_fifo_level), 32'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rst_n = 1'b0;
        step(2);
        chk("t6_rst_level",   32'(o_fifo_level), 32'd0);
        chk("t6_rst_valid",   32'(o_ev_valid), 32'd0);
        chk("t6_rst_evdata",  32'(o_ev_data), 32'd0);
        chk("t6_rst_rx",      32'(o_rx_byte), 32'd0);
        chk("t6_rst_keycode", o_keycodeout, 32'd0);
        chk("t6_rst_pulses",  32'({o_byte_valid, o_err_parity, o_err_frame, o_err_timeout, o_overflow}), 32'd0);
        rst_n = 1'b1;
        i_ev_ready = 1'b1;
        step(5);
        clr();
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("t6_post_cnt", 32'(ev_q.size()), 32'd1);
        if (ev_q.size() > 0) chk("t6_post_ev", 32'(ev_q[0]), 32'h01C);
        chk("t6_post_keycode", o_keycodeout, 32'h0000001C);
        chk("t6_post_errs", 32'(n_pe + n_fe + n_to), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
